ss_skid_slice: RTL and testbench

Parametrised register slice for the ss streaming interface (valid/ready/data/keep/last/user) on a single clock. It breaks timing paths between stream stages and selects by parameter between bypass, forward-only registering, and a full two-entry skid buffer that registers both the forward path and `ready` with no throughput loss. It adds a synchronous flush for discarding in-flight beats. It is the standard pipeline element dropped between ss stages in the datapath.

---
 rtl/ss_skid_slice.sv | 137 +++++++++++++
 tb/tb_ss_skid_slice.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_skid_slice.sv
// Register slice for the ss stream (valid/ready/data/keep/last/user).
// MODE selects bypass, forward-registered, or full two-entry skid with registered ready.
module ss_skid_slice #(
    parameter int DATA_W = 64,
    parameter int USER_W = 1,
    parameter int MODE   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    input  logic [USER_W-1:0]   in_user,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_last,
    output logic [USER_W-1:0]   out_user,
    output logic [1:0]          occupancy
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int WORD_W = DATA_W + KEEP_W + 1 + USER_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    logic [WORD_W-1:0] in_word_s;
    logic [WORD_W-1:0] out_word_s;

    // Payload fields always move as one word.
    assign in_word_s = {in_data, in_keep, in_last, in_user};
    assign {out_data, out_keep, out_last, out_user} = out_word_s;

    if (MODE == 0) begin : g_bypass
        logic unused_s;
        assign unused_s   = ^{clk, rst, flush};
        assign out_word_s = in_word_s;
        assign out_valid  = in_valid;
        assign in_ready   = out_ready;
        assign occupancy  = 2'd0;
    end else if (MODE == 1) begin : g_fwd
        logic [WORD_W-1:0] main_r;
        logic              valid_r;
        logic              load_s;

        assign in_ready   = (out_ready | ~valid_r) & ~rst;
        assign load_s     = in_valid & in_ready;
        assign out_word_s = main_r;
        assign out_valid  = valid_r;
        assign occupancy  = {1'b0, valid_r};

        // Main register: load on accept, drain on output transfer, drop on flush/reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_r <= 1'b0;
            end else if (flush) begin
                valid_r <= 1'b0;
            end else if (load_s) begin
                main_r  <= in_word_s;
                valid_r <= 1'b1;
            end else if (out_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end else begin : g_skid
        logic [WORD_W-1:0] main_r;
        logic [WORD_W-1:0] skid_r;
        state_e            state_r;
        logic              valid_r;
        logic              ready_r;
        logic [1:0]        occ_r;

        // ready_r is a flop; rst only masks it so nothing is taken during reset.
        assign in_ready   = ready_r & ~rst;
        assign out_word_s = main_r;
        assign out_valid  = valid_r;
        assign occupancy  = occ_r;

        // Skid FSM with registered valid, ready and occupancy.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                state_r <= ST_EMPTY;
                valid_r <= 1'b0;
                ready_r <= 1'b1;
                occ_r   <= 2'd0;
            end else begin
                case (state_r)
                    ST_EMPTY: begin
                        if (in_valid) begin
                            main_r  <= in_word_s;
                            state_r <= ST_BUSY;
                            valid_r <= 1'b1;
                            occ_r   <= 2'd1;
                        end
                    end
                    ST_BUSY: begin
                        if (in_valid && out_ready) begin
                            main_r <= in_word_s;
                        end else if (in_valid) begin
                            skid_r  <= in_word_s;
                            state_r <= ST_FULL;
                            ready_r <= 1'b0;
                            occ_r   <= 2'd2;
                        end else if (out_ready) begin
                            state_r <= ST_EMPTY;
                            valid_r <= 1'b0;
                            occ_r   <= 2'd0;
                        end
                    end
                    ST_FULL: begin
                        if (out_ready) begin
                            main_r  <= skid_r;
                            state_r <= ST_BUSY;
                            ready_r <= 1'b1;
                            occ_r   <= 2'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        occ_r   <= 2'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ss_skid_slice.sv
// Directed and random bench for ss_skid_slice; one instance per MODE (index = MODE).
module tb_ss_skid_slice;
    localparam int DW = 16;
    localparam int KW = DW / 8;
    localparam int UW = 2;
    localparam int W  = DW + KW + 1 + UW;
    localparam int NB = 1000;

    localparam logic [1:0] BP_OCC [12] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    localparam logic       BP_RDY [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [7:0] BP_OUT [12] = '{8'h00, 8'h20, 8'h21, 8'h22, 8'h22, 8'h22, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic          in_valid [3];
    logic          in_ready [3];
    logic [DW-1:0] in_data  [3];
    logic [KW-1:0] in_keep  [3];
    logic          in_last  [3];
    logic [UW-1:0] in_user  [3];
    logic          out_valid[3];
    logic          out_ready[3];
    logic [DW-1:0] out_data [3];
    logic [KW-1:0] out_keep [3];
    logic          out_last [3];
    logic [UW-1:0] out_user [3];
    logic [1:0]    occupancy[3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ss_skid_slice #(.DATA_W(DW), .USER_W(UW), .MODE(g)) u_dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
            .in_keep(in_keep[g]), .in_last(in_last[g]), .in_user(in_user[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
            .out_keep(out_keep[g]), .out_last(out_last[g]), .out_user(out_user[g]),
            .occupancy(occupancy[g])
        );
    end

    function automatic logic [W-1:0] gen(input int k, input int i);
        logic [DW-1:0] d;
        logic [KW-1:0] kp;
        logic          l;
        logic [UW-1:0] u;
        d  = 16'(i + k * 4096);
        kp = 2'((i >> 1) + 1);
        l  = (i % 7 == 6);
        u  = 2'(i + k);
        return {d, kp, l, u};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic v, input logic [DW-1:0] d, input logic l);
        in_valid[k] = v;
        in_data[k]  = d;
        in_keep[k]  = 2'b11;
        in_last[k]  = l;
        in_user[k]  = 2'b01;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv(k, 1'b0, 16'h0, 1'b0);
            out_ready[k] = 1'b1;
        end
        step();
        step();
        for (int k = 1; k < 3; k++) begin
            tests++;
            if ({out_valid[k], occupancy[k], in_ready[k]} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_state mode%0d: got v/occ/rdy=%b%b%b exp 0000", k, out_valid[k], occupancy[k], in_ready[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 1; k < 3; k++) begin
            tests++;
            if (in_ready[k] !== 1'b1) begin
                fails++;
                $display("FAIL reset_release_ready mode%0d: got %b exp 1", k, in_ready[k]);
            end
        end
        step();
        for (int k = 1; k < 3; k++) out_ready[k] = 1'b0;
    endtask

    task automatic test_stream();
        out_ready[2] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drv(2, i < 16, 16'(i), i == 15);
            #1;
            tests++;
            if (in_ready[2] !== 1'b1) begin
                fails++;
                $display("FAIL stream_ready beat %0d: got %b exp 1", i, in_ready[2]);
            end
            if (i > 0) begin
                tests++;
                if ({out_valid[2], out_data[2], out_last[2]} !== {1'b1, 16'(i - 1), (i == 16)}) begin
                    fails++;
                    $display("FAIL stream_out cycle %0d: got v=%b d=%0h l=%b exp v=1 d=%0h l=%b",
                             i, out_valid[2], out_data[2], out_last[2], i - 1, (i == 16));
                end
            end
            step();
        end
        drv(2, 1'b0, 16'h0, 1'b0);
        #1;
        tests++;
        if (out_valid[2] !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: got out_valid=%b exp 0", out_valid[2]);
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready[2] = !(c >= 3 && c <= 5);
            drv(2, 1'b1, 16'(16'h20 + t), 1'b0);
            #1;
            tests++;
            if ({occupancy[2], in_ready[2]} !== {BP_OCC[c], BP_RDY[c]}) begin
                fails++;
                $display("FAIL bp_occ_ready cycle %0d: got occ=%0d rdy=%b exp occ=%0d rdy=%b",
                         c, occupancy[2], in_ready[2], BP_OCC[c], BP_RDY[c]);
            end
            if (c > 0) begin
                tests++;
                if ({out_valid[2], out_data[2]} !== {1'b1, 8'h00, BP_OUT[c]}) begin
                    fails++;
                    $display("FAIL bp_out cycle %0d: got v=%b d=%0h exp v=1 d=%0h", c, out_valid[2], out_data[2], BP_OUT[c]);
                end
            end
            if (in_ready[2]) t++;
            step();
        end
        drv(2, 1'b0, 16'h0, 1'b0);
        #1;
        tests++;
        if ({out_valid[2], out_data[2]} !== {1'b1, 16'h28}) begin
            fails++;
            $display("FAIL bp_last: got v=%b d=%0h exp v=1 d=28", out_valid[2], out_data[2]);
        end
        step();
        tests++;
        if ({out_valid[2], occupancy[2]} !== 3'b000) begin
            fails++;
            $display("FAIL bp_empty: got v=%b occ=%0d exp 0/0", out_valid[2], occupancy[2]);
        end
    endtask

    task automatic test_flush();
        out_ready[2] = 1'b0;
        drv(2, 1'b1, 16'h000A, 1'b0);
        step();
        drv(2, 1'b1, 16'h000B, 1'b0);
        step();
        drv(2, 1'b1, 16'h000C, 1'b0);
        flush = 1'b1;
        #1;
        tests++;
        if ({in_ready[2], occupancy[2], out_data[2]} !== {1'b0, 2'd2, 16'h000A}) begin
            fails++;
            $display("FAIL flush_full_pre: got rdy=%b occ=%0d d=%0h exp 0/2/a", in_ready[2], occupancy[2], out_data[2]);
        end
        step();
        flush = 1'b0;
        out_ready[2] = 1'b1;
        drv(2, 1'b1, 16'h000D, 1'b0);
        #1;
        tests++;
        if ({out_valid[2], occupancy[2], in_ready[2]} !== 4'b0001) begin
            fails++;
            $display("FAIL flush_full_post: got v=%b occ=%0d rdy=%b exp 0/0/1", out_valid[2], occupancy[2], in_ready[2]);
        end
        step();
        drv(2, 1'b0, 16'h0, 1'b0);
        #1;
        tests++;
        if ({out_valid[2], out_data[2]} !== {1'b1, 16'h000D}) begin
            fails++;
            $display("FAIL flush_next_beat: got v=%b d=%0h exp v=1 d=d", out_valid[2], out_data[2]);
        end
        step();
        // Flush in BUSY: the offered beat is discarded even though in_ready reads 1.
        out_ready[2] = 1'b0;
        drv(2, 1'b1, 16'h000E, 1'b0);
        step();
        drv(2, 1'b1, 16'h000F, 1'b0);
        flush = 1'b1;
        #1;
        tests++;
        if ({in_ready[2], occupancy[2]} !== {1'b1, 2'd1}) begin
            fails++;
            $display("FAIL flush_busy_pre: got rdy=%b occ=%0d exp 1/1", in_ready[2], occupancy[2]);
        end
        step();
        flush = 1'b0;
        drv(2, 1'b0, 16'h0, 1'b0);
        #1;
        tests++;
        if ({out_valid[2], occupancy[2]} !== 3'b000) begin
            fails++;
            $display("FAIL flush_busy_post: got v=%b occ=%0d exp 0/0", out_valid[2], occupancy[2]);
        end
    endtask

    task automatic test_reset_mid();
        out_ready[2] = 1'b0;
        drv(2, 1'b1, 16'h0030, 1'b0);
        step();
        drv(2, 1'b1, 16'h0031, 1'b0);
        step();
        drv(2, 1'b1, 16'h0032, 1'b0);
        #1;
        tests++;
        if (occupancy[2] !== 2'd2) begin
            fails++;
            $display("FAIL rstmid_full: got occ=%0d exp 2", occupancy[2]);
        end
        rst = 1'b1;
        step();
        tests++;
        if ({out_valid[2], in_ready[2], occupancy[2]} !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_during: got v=%b rdy=%b occ=%0d exp 0/0/0", out_valid[2], in_ready[2], occupancy[2]);
        end
        rst = 1'b0;
        drv(2, 1'b0, 16'h0, 1'b0);
        out_ready[2] = 1'b1;
        #1;
        tests++;
        if (in_ready[2] !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_release: got rdy=%b exp 1", in_ready[2]);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (out_valid[2] !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_stale cycle %0d: got v=%b d=%0h exp v=0", i, out_valid[2], out_data[2]);
            end
        end
        out_ready[2] = 1'b0;
    endtask

    task automatic test_comb_ready();
        out_ready[1] = 1'b0;
        drv(1, 1'b1, 16'h0040, 1'b0);
        #1;
        tests++;
        if (in_ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL m1_empty_ready: got %b exp 1", in_ready[1]);
        end
        step();
        drv(1, 1'b1, 16'h0041, 1'b0);
        #1;
        tests++;
        if ({in_ready[1], out_valid[1], out_data[1]} !== {2'b01, 16'h0040}) begin
            fails++;
            $display("FAIL m1_stall: got rdy=%b v=%b d=%0h exp 0/1/40", in_ready[1], out_valid[1], out_data[1]);
        end
        out_ready[1] = 1'b1;
        #1;
        tests++;
        if (in_ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL m1_comb_ready: got %b exp 1", in_ready[1]);
        end
        step();
        drv(1, 1'b0, 16'h0, 1'b0);
        #1;
        tests++;
        if ({out_valid[1], out_data[1], occupancy[1]} !== {1'b1, 16'h0041, 2'd1}) begin
            fails++;
            $display("FAIL m1_reload: got v=%b d=%0h occ=%0d exp 1/41/1", out_valid[1], out_data[1], occupancy[1]);
        end
        step();
        tests++;
        if ({out_valid[1], occupancy[1]} !== 3'b000) begin
            fails++;
            $display("FAIL m1_drain: got v=%b occ=%0d exp 0/0", out_valid[1], occupancy[1]);
        end
        // Bypass: everything passes straight through in the same cycle.
        out_ready[0] = 1'b0;
        drv(0, 1'b1, 16'h0055, 1'b1);
        #1;
        tests++;
        if ({out_valid[0], out_data[0], out_last[0], in_ready[0], occupancy[0]} !== {1'b1, 16'h0055, 1'b1, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL m0_bypass: got v=%b d=%0h l=%b rdy=%b occ=%0d exp 1/55/1/0/0",
                     out_valid[0], out_data[0], out_last[0], in_ready[0], occupancy[0]);
        end
        drv(0, 1'b0, 16'h0, 1'b0);
        step();
    endtask

    task automatic test_random();
        int            txn [3];
        int            rxn [3];
        logic          acc [3];
        logic          hold[3];
        logic [W-1:0]  prev_w[3];
        logic [W-1:0]  w;
        for (int k = 0; k < 3; k++) begin
            txn[k] = 0;
            rxn[k] = 0;
            acc[k] = 1'b0;
            hold[k] = 1'b0;
            prev_w[k] = '0;
            in_valid[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (rxn[0] >= NB && rxn[1] >= NB && rxn[2] >= NB) break;
            for (int k = 0; k < 3; k++) begin
                if (!in_valid[k] || acc[k]) begin
                    in_valid[k] = (txn[k] < NB) && ($urandom_range(1, 0) == 1);
                    {in_data[k], in_keep[k], in_last[k], in_user[k]} = gen(k, txn[k]);
                end
                out_ready[k] = ($urandom_range(1, 0) == 1);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                w = {out_data[k], out_keep[k], out_last[k], out_user[k]};
                if (hold[k]) begin
                    tests++;
                    if (!out_valid[k] || w !== prev_w[k]) begin
                        fails++;
                        $display("FAIL rand_stable mode%0d: got v=%b w=%0h exp v=1 w=%0h", k, out_valid[k], w, prev_w[k]);
                    end
                end
                acc[k] = in_valid[k] && in_ready[k];
                if (acc[k]) txn[k]++;
                if (out_valid[k] && out_ready[k]) begin
                    tests++;
                    if (w !== gen(k, rxn[k])) begin
                        fails++;
                        $display("FAIL rand_data mode%0d beat %0d: got %0h exp %0h", k, rxn[k], w, gen(k, rxn[k]));
                    end
                    rxn[k]++;
                end
                hold[k] = out_valid[k] && !out_ready[k];
                prev_w[k] = w;
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (rxn[k] != NB || txn[k] != NB) begin
                fails++;
                $display("FAIL rand_count mode%0d: got sent=%0d recv=%0d exp %0d", k, txn[k], rxn[k], NB);
            end
            in_valid[k] = 1'b0;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_comb_ready();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
